// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// One result bit per cycle: shift-add multiply, restoring divide, with a
// sign-fix cycle and early exit for divide-by-zero and signed overflow.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   busy_nxt, done_nxt;

  logic [2:0]         op;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_p, neg_r;

  logic               is_div, a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   special_res;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum, rs, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_res;

  // Operand decode, special-case detection and per-iteration arithmetic
  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = is_div ? ~op[0] : ~op[1];
    sa       = a_signed & opa[WIDTH-1];
    sb       = b_signed & opb[WIDTH-1];
    abs_a    = sa ? -opa : opa;
    abs_b    = sb ? -opb : opb;

    div_zero = is_div & (opb == '0);
    div_ovf  = is_div & ~op[0] & (opa == MINV) & (opb == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      special_res = op[1] ? opa : '1;
    else
      special_res = op[1] ? '0 : MINV;

    last_iter = (cnt == CW'(WIDTH - 1));

    // Multiply: conditional add into the high half, whole accumulator shifts right
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (a_reg[0] ? {1'b0, b_reg} : '0);
    // Divide: partial remainder lives in the high half, dividend/quotient in a_reg
    rs      = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
    diff    = rs - {1'b0, b_reg};

    prod = neg_p ? -acc : acc;
    quot = neg_p ? -a_reg : a_reg;
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 fix_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  // Next-state and registered-output decode; Flush overrides everything
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (Start) state_nxt = S_PREP;
        S_PREP: state_nxt = special ? S_DONE : S_CALC;
        S_CALC: if (last_iter) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
    busy_nxt = (state_nxt == S_PREP) || (state_nxt == S_CALC) || (state_nxt == S_FIX);
    done_nxt = (state_nxt == S_DONE);
  end

  // State register with registered Busy/Done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= busy_nxt;
      Done  <= done_nxt;
    end
  end

  // Datapath: operand capture, iteration, and result registration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      Result <= '0;
    end else if (!Flush) begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            op  <= Funct3;
            opa <= SrcA;
            opb <= SrcB;
          end
        end
        S_PREP: begin
          a_reg <= abs_a;
          b_reg <= abs_b;
          acc   <= '0;
          cnt   <= '0;
          neg_p <= sa ^ sb;
          neg_r <= sa;
          if (special) Result <= special_res;
        end
        S_CALC: begin
          if (is_div) begin
            a_reg                   <= {a_reg[WIDTH-2:0], ~diff[WIDTH]};
            acc[2*WIDTH-1:WIDTH]    <= diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
          end else begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            a_reg <= a_reg >> 1;
          end
          cnt <= last_iter ? '0 : cnt + CW'(1);
        end
        S_FIX: begin
          Result <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign Stall = ((state == S_IDLE) & Start & ~Flush) | Busy;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer.
module tb_mdu_sequencer;

  localparam int unsigned W = 32;
  localparam int NORM = W + 2;
  localparam int SPEC = 1;

  logic         clk = 1'b0;
  logic         reset, Start, Flush;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Done, Stall;
  logic [W-1:0] Result;

  int n_cmp = 0;
  int n_err = 0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Flush  (Flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Stall  (Stall),
    .Result (Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, scramble inputs after acceptance, wait for Done.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                        input int poke_at);
    int k;
    bit seen;
    bit stall_ok;
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
    #1;
    check({tag, ".stall_req"}, W'(Stall), W'(1));
    step();
    Start  = 1'b0;
    Funct3 = ~f3;
    SrcA   = ~a;
    SrcB   = b ^ 32'h5A5A_A5A5;
    stall_ok = (Stall === 1'b1) && (Busy === 1'b1);
    k = 0;
    seen = 0;
    while (!seen && k < 60) begin
      step();
      k++;
      if (Done === 1'b1) seen = 1;
      else if (!((Stall === 1'b1) && (Busy === 1'b1))) stall_ok = 0;
      if (!seen && k == poke_at) begin
        Start  = 1'b1;
        Funct3 = 3'b101;
        SrcA   = 32'h0000_1234;
        SrcB   = 32'h0000_0003;
      end else begin
        Start = 1'b0;
      end
    end
    check({tag, ".latency"}, W'(k), W'(lat));
    check({tag, ".result"}, Result, exp);
    check({tag, ".stall_thru"}, W'(stall_ok), W'(1));
    check({tag, ".idle_at_done"}, W'({Busy, Stall}), W'(0));
    step();
    check({tag, ".done_pulse"}, W'(Done), W'(0));
  endtask

  initial begin
    int k;
    bit any_done;
    reset  = 1'b1;
    Start  = 1'b0;
    Flush  = 1'b0;
    Funct3 = 3'b000;
    SrcA   = '0;
    SrcB   = '0;
    repeat (2) step();
    check("rst.busy", W'(Busy), W'(0));
    check("rst.done", W'(Done), W'(0));
    check("rst.result", Result, W'(0));
    check("rst.stall", W'(Stall), W'(0));
    reset = 1'b0;
    step();

    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM, 0);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORM, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, NORM, 0);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, NORM, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, NORM, 0);
    run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        NORM, 0);
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         NORM, 0);
    run_op("div0",   3'b100, 32'h0000_0033, 32'h0000_0000, 32'hFFFF_FFFF, SPEC, 0);
    run_op("rem0",   3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPEC, 0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC, 0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC, 0);
    run_op("mulpoke", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM, 8);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, NORM, 0);

    // Flush beats Start in IDLE
    Start  = 1'b1;
    Flush  = 1'b1;
    Funct3 = 3'b000;
    SrcA   = 32'd5;
    SrcB   = 32'd6;
    #1;
    check("flush_idle.stall", W'(Stall), W'(0));
    step();
    check("flush_idle.busy", W'(Busy), W'(0));
    Start = 1'b0;
    Flush = 1'b0;
    step();

    // Flush at CALC iteration 10
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (11) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("flush_calc.busy", W'(Busy), W'(0));
    check("flush_calc.stall", W'(Stall), W'(0));
    check("flush_calc.result", Result, 32'h0000_FFFF);
    any_done = 0;
    for (k = 0; k < 40; k++) begin
      if (Done === 1'b1) any_done = 1;
      step();
    end
    check("flush_calc.no_done", W'(any_done), W'(0));
    check("flush_calc.result_kept", Result, 32'h0000_FFFF);

    // Asynchronous reset in the middle of CALC
    Funct3 = 3'b000;
    SrcA   = 32'd9;
    SrcB   = 32'd9;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    repeat (15) step();
    reset = 1'b1;
    #1;
    check("arst.busy", W'(Busy), W'(0));
    check("arst.done", W'(Done), W'(0));
    check("arst.result", Result, W'(0));
    check("arst.stall", W'(Stall), W'(0));
    step();
    reset = 1'b0;
    step();
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, NORM, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
